// File: rtl/aes_job_sequencer.sv
// Job sequencer in front of aes_top: accepts one key/plaintext job, launches the core, supervises
// done/fault/timeout and returns one result. Define AES_SEQ_RETRY_EN to re-launch after fault-flagged results.
module aes_job_sequencer #(
  parameter int TIMEOUT_CYCLES = 4000,
  parameter int MAX_RETRY      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_pt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ct,
  output logic         out_fault,
  output logic         out_timeout,
  output logic [15:0]  fault_cnt,
  output logic         aes_start,
  output logic [127:0] aes_key,
  output logic [127:0] aes_pt,
  input  logic         aes_busy,
  input  logic         aes_done,
  input  logic [127:0] aes_ct,
  input  logic         aes_fault
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both 1. Once out_valid
  // rises it stays high with out_ct/out_fault/out_timeout frozen until out_ready is seen.

`ifdef AES_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam int WCNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int RCNT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WCNT_W-1:0]   wait_cnt;
  logic [RCNT_W-1:0]   retry_cnt;

  logic accept;
  logic done_qual;
  logic timeout_hit;
  logic retry_ok;
  logic do_capture;
  logic do_fault_end;
  logic do_timeout;
  logic do_retry;
  logic fault_seen;
  logic busy_unused;

  // The core's busy flag is informational only; done is the completion event.
  assign busy_unused = aes_busy;

  // The first WAIT cycle has wait_cnt == 0, so a done level left over from the previous job is ignored.
  assign done_qual   = aes_done && (wait_cnt != '0);
  assign timeout_hit = (32'(wait_cnt) >= (TIMEOUT_CYCLES - 1));
  assign retry_ok    = RETRY_EN && (32'(retry_cnt) < MAX_RETRY);

  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    aes_start    = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;
    do_capture   = 1'b0;
    do_fault_end = 1'b0;
    do_timeout   = 1'b0;
    do_retry     = 1'b0;
    fault_seen   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        aes_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A qualified done wins over a timeout landing in the same cycle.
        if (done_qual) begin
          if (!aes_fault) begin
            do_capture = 1'b1;
            state_next = S_RESP;
          end else begin
            fault_seen = 1'b1;
            if (retry_ok) begin
              do_retry   = 1'b1;
              state_next = S_LAUNCH;
            end else begin
              do_fault_end = 1'b1;
              state_next   = S_RESP;
            end
          end
        end else if (timeout_hit) begin
          do_timeout = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      retry_cnt   <= '0;
      aes_key     <= '0;
      aes_pt      <= '0;
      out_ct      <= '0;
      out_fault   <= 1'b0;
      out_timeout <= 1'b0;
      fault_cnt   <= '0;
    end else begin
      state <= state_next;

      if (accept) begin
        aes_key     <= in_key;
        aes_pt      <= in_pt;
        retry_cnt   <= '0;
        wait_cnt    <= '0;
        out_ct      <= '0;
        out_fault   <= 1'b0;
        out_timeout <= 1'b0;
      end else if (state == S_LAUNCH) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end

      if (do_retry) retry_cnt <= retry_cnt + RCNT_W'(1);

      if (fault_seen && (fault_cnt != 16'hFFFF)) fault_cnt <= fault_cnt + 16'd1;

      // Ciphertext is only released for a clean completion.
      if (do_capture) begin
        out_ct      <= aes_ct;
        out_fault   <= 1'b0;
        out_timeout <= 1'b0;
      end else if (do_fault_end) begin
        out_ct      <= '0;
        out_fault   <= 1'b1;
        out_timeout <= 1'b0;
      end else if (do_timeout) begin
        out_ct      <= '0;
        out_fault   <= 1'b0;
        out_timeout <= 1'b1;
      end
    end
  end

endmodule
